// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if
// Groups the run-control, breakpoint and status signals that pass between
// the CPU clock/run controller and the CPU plus its debug host.
//
// Parameters:
//   RATIO  clk cycles per CPU cycle (sets the width of phase)
//   PC_W   width of pc and bp_addr
//   CNT_W  width of cyc_cnt
//
// Signals (directions as seen by the controller, modport slave):
//   run      in   level, 1 = free-run, 0 = halt at the next CPU-cycle boundary
//   step     in   pulse, request one CPU cycle while halted
//   bp_en    in   breakpoint enable
//   bp_addr  in   breakpoint PC
//   pc       in   current CPU PC
//   cpu_rst  out  stretched reset to the CPU datapath
//   cpu_ce   out  CPU commit enable (single clk cycle)
//   phase    out  position within the CPU cycle
//   halted   out  controller is in HALT
//   bp_hit   out  sticky breakpoint flag
//   cyc_cnt  out  CPU cycles committed
//   state    out  RESET=0, HALT=1, RUN=2
interface cpu_clk_ctrl_if #(
    parameter int RATIO = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic             run;
    logic             step;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             cpu_rst;
    logic             cpu_ce;
    logic [PH_W-1:0]  phase;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] cyc_cnt;
    logic [1:0]       state;

    // The controller side
    modport slave (
        input  run, step, bp_en, bp_addr, pc,
        output cpu_rst, cpu_ce, phase, halted, bp_hit, cyc_cnt, state
    );

    // The CPU / debug host side
    modport master (
        output run, step, bp_en, bp_addr, pc,
        input  cpu_rst, cpu_ce, phase, halted, bp_hit, cyc_cnt, state
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
// Clock-enable, reset and run-control block for the single-cycle CPU. The
// whole CPU runs on the memory-rate clock; this block divides it into CPU
// cycles of RATIO clks and grants a one-clk commit enable at the last clk of
// a CPU cycle (the boundary). It also stretches the CPU reset, and provides
// run/halt, single-step, a PC breakpoint and a committed-cycle counter.
//
// Parameters:
//   RATIO       clk cycles per CPU cycle (>= 2)
//   RST_CYCLES  CPU cycles that cpu_rst stays high after rst deasserts (>= 1)
//   PC_W        PC / breakpoint width
//   CNT_W       cycle counter width
//
// Ports:
//   clk  single clock, all logic on the rising edge
//   rst  asynchronous active-high reset
//   bus  cpu_clk_ctrl_if.slave (run, step, bp_en, bp_addr, pc in;
//        cpu_rst, cpu_ce, phase, halted, bp_hit, cyc_cnt, state out)
module cpu_clk_ctrl #(
    parameter int RATIO      = 4,
    parameter int RST_CYCLES = 2,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpu_clk_ctrl_if.slave bus
);
    localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HALT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PH_W-1:0]  phase_q;
    logic [RC_W-1:0]  rst_cnt_q;
    logic             step_pend_q;
    logic             resume_q;
    logic             cpu_rst_q;
    logic             halted_q;
    logic             bp_hit_q;
    logic [CNT_W-1:0] cyc_cnt_q;

    logic             boundary;
    logic             bp_match;
    logic             commit;
    logic             bp_stop;
    logic             leave_reset;
    logic             set_resume;
    logic [PC_W-1:0]  pc_s;
    logic [PC_W-1:0]  bp_addr_s;

    assign pc_s      = bus.pc;
    assign bp_addr_s = bus.bp_addr;

    assign boundary = (phase_q == PH_LAST);

    // The first RUN boundary after leaving HALT ignores the breakpoint so
    // execution can move past the PC it stopped on.
    assign bp_match = bus.bp_en && (pc_s == bp_addr_s) && !resume_q;

    // Phase counter: free-running in every state, only rst restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else if (boundary) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 1'b1;
        end
    end

    // State register of the run-control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and commit decision. Everything is decided only in the
    // boundary cycle, so run/pc/bp_* are effectively sampled there. In HALT a
    // step (pending or arriving right now) wins over run.
    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        bp_stop     = 1'b0;
        leave_reset = 1'b0;
        set_resume  = 1'b0;
        if (boundary) begin
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == RC_LAST) begin
                        leave_reset = 1'b1;
                        state_d     = bus.run ? ST_RUN : ST_HALT;
                    end
                end
                ST_RUN: begin
                    if (!bus.run) begin
                        state_d = ST_HALT;
                    end else if (bp_match) begin
                        bp_stop = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        commit = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (step_pend_q || bus.step) begin
                        commit = 1'b1;
                    end else if (bus.run) begin
                        state_d    = ST_RUN;
                        set_resume = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // Reset stretcher: counts boundaries spent in RESET and drops cpu_rst on
    // the boundary that leaves RESET. Only rst can bring the FSM back here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt_q <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            if (state_q == ST_RESET && boundary) begin
                rst_cnt_q <= leave_reset ? '0 : rst_cnt_q + 1'b1;
            end
            if (leave_reset) begin
                cpu_rst_q <= 1'b0;
            end
        end
    end

    // Step request latch. Pulses are only remembered while halted and any
    // number of them within one CPU cycle collapse into one request. At a
    // HALT boundary a pending or live step is always consumed by a commit,
    // so the latch can simply clear on every boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_pend_q <= 1'b0;
        end else begin
            step_pend_q <= (state_q == ST_HALT) && !boundary &&
                           (step_pend_q || bus.step);
        end
    end

    // Resume flag lives from the HALT->RUN boundary to the next RUN boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resume_q <= 1'b0;
        end else if (state_q == ST_RUN && boundary) begin
            resume_q <= 1'b0;
        end else if (set_resume) begin
            resume_q <= 1'b1;
        end
    end

    // Commit bookkeeping and status flags. A commit always clears a sticky
    // breakpoint hit, since the CPU has moved on from the halting PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            bp_hit_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            if (commit) begin
                cyc_cnt_q <= cyc_cnt_q + 1'b1;
                bp_hit_q  <= 1'b0;
            end else if (bp_stop) begin
                bp_hit_q  <= 1'b1;
            end
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign bus.cpu_ce  = commit;
    assign bus.cpu_rst = cpu_rst_q;
    assign bus.phase   = phase_q;
    assign bus.halted  = halted_q;
    assign bus.bp_hit  = bp_hit_q;
    assign bus.cyc_cnt = cyc_cnt_q;
    assign bus.state   = state_q;
endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Parametrised clock-enable, reset and run-control block for the single-cycle CPU. It runs on one fast clock at memory rate and produces a one-cycle CPU commit enable every RATIO clocks, so the CPU no longer needs a separate slow clock alongside the memory clock. It adds a stretched CPU reset, run/halt control, single-step, a PC breakpoint and a retired-cycle counter for bring-up and debug.

## Interface
- RATIO, 4: clk cycles per CPU cycle; ≥2
- RST_CYCLES, 2: CPU cycles that cpu_rst is held after rst deasserts; ≥1
- PC_W, 32: PC / breakpoint width
- CNT_W, 32: cycle counter width
- clk  in  1  single clock, memory rate; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = free-run, 0 = halt at next CPU-cycle boundary
- step  in  1  pulse; request one CPU cycle while halted
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint PC
- pc  in  PC_W  current CPU PC
- cpu_rst  out  1  reset to CPU datapath, registered
- cpu_ce  out  1  CPU commit enable; the CPU updates PC/regs/memory on the clk edge where cpu_ce=1
- phase  out  $clog2(RATIO)  position within CPU cycle
- halted  out  1  state is HALT
- bp_hit  out  1  sticky breakpoint flag
- cyc_cnt  out  CNT_W  CPU cycles committed
- state  out  2  RESET=0, HALT=1, RUN=2

## Operation
- phase counts 0..RATIO-1 and wraps, free-running in every state. Boundary = clk cycle with phase==RATIO-1. All state decisions are made only at boundaries.
- cpu_ce is the only Mealy output: asserted combinationally during a boundary cycle when a commit is granted; every other output is registered.
- RESET: cpu_rst=1, cpu_ce=0. The internal counter counts boundaries. At the RST_CYCLES-th boundary:
  - cpu_rst clears.
  - Next state is RUN if run=1, else HALT.
  - No commit occurs at this boundary.
- RUN: at each boundary, in priority order:
  - run=0: no commit; go to HALT.
  - Breakpoint match (bp_en && pc==bp_addr && !resume): no commit; bp_hit<=1; go to HALT.
  - Otherwise: commit.
- HALT:
  - step is latched into step_pend on any cycle. Multiple pulses within one CPU cycle coalesce into one pending request.
  - At a boundary, if step_pend or step: commit, clear step_pend, stay in HALT. Breakpoints are not checked on a step.
  - Otherwise, if run=1: go to RUN and set resume.
  - step has priority over run at the same boundary.
- resume suppresses the breakpoint check at the first RUN boundary only, so execution can continue past the halting PC. resume clears at that boundary.
- step asserted while in RUN or RESET is ignored and not latched.
- Every commit does cyc_cnt<=cyc_cnt+1, wrapping modulo 2^CNT_W, and clears bp_hit.
- halted = (state==HALT).

## Timing
- rst asserted (asynchronous, any phase): immediately state=RESET, phase=0, cpu_rst=1, cpu_ce=0, halted=0, bp_hit=0, cyc_cnt=0, step_pend=0, resume=0. This also applies to a reset asserted mid-run.
- After rst deasserts, cpu_rst falls at the edge ending clk cycle RST_CYCLES·RATIO.
- The first possible commit is RATIO clk cycles after that.
- Commit rate: at most one cpu_ce per RATIO clk cycles. cpu_ce is never high for two consecutive cycles.
- run, pc and bp_* are sampled in the boundary cycle only. Changes between boundaries have no effect.
- Latency, step pulse to cpu_ce: the next boundary. If the pulse arrives in a boundary cycle, cpu_ce fires in that same cycle.
- A breakpoint halt takes effect at the boundary; the instruction at bp_addr is not committed.

## Test plan
- Reset, RATIO=4, RST_CYCLES=2, run=1: release rst → cpu_rst=1 for 8 clk, then 0; first cpu_ce during clk cycle 12 (phase=3); cyc_cnt=1 afterwards; state RESET→RUN.
- Free-run: run=1 for 40 clk after reset exit → cpu_ce exactly every 4th cycle (10 pulses), cyc_cnt=10; drop run at phase 1 → no cpu_ce at the next boundary, halted=1, cyc_cnt stays 10.
- Breakpoint: bp_en=1, bp_addr=0x10, PC model +4 per cpu_ce starting at 0 → commits at pc 0,4,8,0xC; at pc=0x10 no cpu_ce, bp_hit=1, halted=1, cyc_cnt=4.
- Single-step: while halted at 0x10, two step pulses at phases 0 and 1 → exactly one cpu_ce at the next phase 3, cyc_cnt=5, bp_hit=0, still halted; step together with run=1 at a boundary → commit, remains HALT.
- Resume: halted at the breakpoint (pc=0x10), raise run → first RUN boundary commits despite pc==bp_addr; the breakpoint fires again when pc returns to 0x10.
- Reset mid-run: assert rst at phase 2 with cyc_cnt=7 → same cycle cpu_rst=1, cpu_ce=0, cyc_cnt=0, phase=0, bp_hit=0, state=RESET.
